switch_event_display: RTL
=========================

// Module: switch_event_display
// PURPOSE
// - Parametrised successor to the lab switch/LED/seven-segment decoder: adds per-switch
//   synchronisation and debounce, a BCD event counter and registered display outputs.
// - Sits between board switches and the LED / seven-segment pins in lab top levels.
// - Shows the highest active switch index and the count of debounced switch-on events.
// PARAMETERS
// - NUM_SWITCHES     18  switch inputs, 1..32
// - NUM_DIGITS       8   seven-segment digits, 3..8; digits [1:0] = index, rest = count
// - DEBOUNCE_CYCLES  50000  consecutive stable samples needed to accept a change, >=2
// PORTS
// - CLOCK_50_I         in   1                 system clock, 50 MHz
// - RESETN_I           in   1                 async reset, active low
// - SWITCH_I           in   NUM_SWITCHES      raw asynchronous switches
// - LED_RED_O          out  NUM_SWITCHES      debounced switch states
// - LED_GREEN_O        out  9                 [4:0] highest active index, [7] overflow, [8] none active
// - SEVEN_SEGMENT_N_O  out  7 x NUM_DIGITS    unpacked [NUM_DIGITS-1:0], active-low, bit[6:0]=g..a
// BEHAVIOUR
// - Reset (async, RESETN_I=0): sync flops, stable states, debounce counters, event count and
//   overflow cleared; LED_RED_O=0; LED_GREEN_O=9'h100; digits [1:0] blank (7'h7F); count
//   digits show 0 (7'h40). Release mid-bounce restarts debounce from stable=0.
// - Sync: each switch through 2 flops; bits [6:5] of LED_GREEN_O tie to 0.
// - Debounce per switch: counter clears whenever synced value equals stable value, else
//   increments; on the edge where it would reach DEBOUNCE_CYCLES, stable <= synced, counter <= 0.
//   A glitch shorter than DEBOUNCE_CYCLES never changes stable.
// - Latency: input step -> LED_RED_O change = 2 + DEBOUNCE_CYCLES cycles.
// - Event: any stable 0->1 transition in a cycle; simultaneous rises on several switches
//   count once. 1->0 transitions never count.
// - Count: (NUM_DIGITS-2)-digit BCD, +1 per event, registered the cycle after the event.
//   At all-nines, next event wraps to 0 and sets LED_GREEN_O[7]; sticky until reset.
// - Index: priority encode of stable states, highest set bit wins; LED_GREEN_O[4:0]=index,
//   [8]=1 when none set (then [4:0]=0). Digits [1:0] show index in decimal (tens, units),
//   tens blank when index<10; both blank when none set.
// - Display: all segment outputs registered; updated one cycle after stable/count change.
//   Digit encodings 0..9 = 40,79,24,30,19,12,02,78,00,10 (hex, active low); blank = 7F.
// CONFIGURATION
// - LEADING_ZERO_BLANK_EN defined: count digits above the least-significant count digit
//   show 7'h7F while they and all higher count digits are 0; digit 2 always shown.
// - Not defined: every count digit always shown, including leading zeros.
// - Index digits [1:0] blanking is independent of the macro.
// TESTING (bench overrides DEBOUNCE_CYCLES=4, NUM_SWITCHES=18, NUM_DIGITS=8)
// - Reset asserted mid-run -> immediately LED_RED_O=0, LED_GREEN_O=9'h100, digit0=7F, digit2=40.
// - SWITCH_I[0] 0->1 held -> LED_RED_O[0]=1 at 6 cycles after step, count digit2=79 one cycle
//   after event, digit0=40, digit1=7F, LED_GREEN_O=9'h000.
// - SWITCH_I[3] pulsed high 3 cycles then low -> LED_RED_O and count unchanged.
// - SWITCH_I[1] and [2] rise same cycle, held -> count +1 only; index 2, digit0=24.
// - SWITCH_I[17] on -> LED_GREEN_O[4:0]=17, digit1=79, digit0=78; switches off -> [8]=1, digits blank.
// - Force count to 999999 via events, one more -> count 0, LED_GREEN_O[7]=1; with
//   LEADING_ZERO_BLANK_EN digits 7..3=7F, digit2=40; without, all count digits 40.

Source files
------------

// File: rtl/switch_event_display.sv
// Debounced switch bank with BCD switch-on event counter and registered LED / seven-segment outputs.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros of the count digits.
module switch_event_display #(
  parameter int unsigned NUM_SWITCHES    = 18,
  parameter int unsigned NUM_DIGITS      = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                    CLOCK_50_I,
  input  logic                    RESETN_I,
  input  logic [NUM_SWITCHES-1:0] SWITCH_I,
  output logic [NUM_SWITCHES-1:0] LED_RED_O,
  output logic [8:0]              LED_GREEN_O,
  output logic [6:0]              SEVEN_SEGMENT_N_O [NUM_DIGITS-1:0]
);

  localparam int unsigned CNT_W      = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned CNT_DIGITS = NUM_DIGITS - 2;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;
  localparam logic [6:0]  SEG_ZERO   = 7'h40;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  logic [NUM_SWITCHES-1:0] sync_meta, sync_q, stable_q, stable_d;
  logic [CNT_W-1:0]        db_cnt_q [NUM_SWITCHES];
  logic [CNT_W-1:0]        db_cnt_d [NUM_SWITCHES];
  logic                    event_q;
  logic                    ovf_q;
  logic [3:0]              bcd_q   [CNT_DIGITS];
  logic [3:0]              bcd_inc [CNT_DIGITS];
  logic                    carry_c;
  logic [4:0]              index_c;
  logic                    none_c;
  logic [3:0]              tens_c, units_c;
  logic                    lead_zero_c;
  logic [6:0]              seg_d [NUM_DIGITS];

  // Debounce: a change is accepted only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(NUM_SWITCHES); i++) begin
      db_cnt_d[i] = '0;
      if (sync_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) stable_d[i] = sync_q[i];
        else db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      sync_meta <= '0;
      sync_q    <= '0;
      stable_q  <= '0;
      event_q   <= 1'b0;
      for (int i = 0; i < int'(NUM_SWITCHES); i++) db_cnt_q[i] <= '0;
    end else begin
      sync_meta <= SWITCH_I;
      sync_q    <= sync_meta;
      stable_q  <= stable_d;
      event_q   <= |(stable_d & ~stable_q);
      for (int i = 0; i < int'(NUM_SWITCHES); i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign LED_RED_O = stable_q;

  // BCD increment; carry out of the top digit means the counter was all nines
  always_comb begin
    carry_c = 1'b1;
    for (int k = 0; k < int'(CNT_DIGITS); k++) begin
      bcd_inc[k] = bcd_q[k];
      if (carry_c) begin
        if (bcd_q[k] == 4'd9) bcd_inc[k] = 4'd0;
        else begin
          bcd_inc[k] = bcd_q[k] + 4'd1;
          carry_c    = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      ovf_q <= 1'b0;
      for (int k = 0; k < int'(CNT_DIGITS); k++) bcd_q[k] <= 4'd0;
    end else if (event_q) begin
      ovf_q <= ovf_q | carry_c;
      for (int k = 0; k < int'(CNT_DIGITS); k++) bcd_q[k] <= bcd_inc[k];
    end
  end

  // Highest set stable bit wins
  always_comb begin
    index_c = '0;
    for (int i = 0; i < int'(NUM_SWITCHES); i++)
      if (stable_q[i]) index_c = 5'(i);
    none_c = ~|stable_q;
  end

  always_comb begin
    if (index_c >= 5'd30) begin
      tens_c = 4'd3; units_c = 4'(index_c - 5'd30);
    end else if (index_c >= 5'd20) begin
      tens_c = 4'd2; units_c = 4'(index_c - 5'd20);
    end else if (index_c >= 5'd10) begin
      tens_c = 4'd1; units_c = 4'(index_c - 5'd10);
    end else begin
      tens_c = 4'd0; units_c = 4'(index_c);
    end
  end

  always_comb begin
    lead_zero_c = 1'b1;
    seg_d[0] = none_c ? SEG_BLANK : seg7(units_c);
    seg_d[1] = (none_c || tens_c == 4'd0) ? SEG_BLANK : seg7(tens_c);
    for (int k = int'(CNT_DIGITS) - 1; k >= 0; k--) begin
      seg_d[k+2] = seg7(bcd_q[k]);
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0 && lead_zero_c && bcd_q[k] == 4'd0) seg_d[k+2] = SEG_BLANK;
      else lead_zero_c = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      LED_GREEN_O          <= 9'h100;
      SEVEN_SEGMENT_N_O[0] <= SEG_BLANK;
      SEVEN_SEGMENT_N_O[1] <= SEG_BLANK;
      for (int d = 2; d < int'(NUM_DIGITS); d++) begin
`ifdef LEADING_ZERO_BLANK_EN
        SEVEN_SEGMENT_N_O[d] <= (d == 2) ? SEG_ZERO : SEG_BLANK;
`else
        SEVEN_SEGMENT_N_O[d] <= SEG_ZERO;
`endif
      end
    end else begin
      LED_GREEN_O <= {none_c, ovf_q, 2'b00, index_c};
      for (int d = 0; d < int'(NUM_DIGITS); d++) SEVEN_SEGMENT_N_O[d] <= seg_d[d];
    end
  end

endmodule
